fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Multi-cycle fetch/PC controller for the RV32I core. It owns the PC register and fetches each instruction from instruction memory over a req/gnt/rvalid handshake. It presents the instruction to the execute datapath, waits for completion, then picks the next PC from the branch unit's NextPCSrc decision and the branch/jump target. It also detects misaligned targets, supports a halt request and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, value driven on instr when no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_gnt  in  1  memory accepted request
imem_rvalid  in  1  read data valid
imem_rdata  in  32  read data
instr  out  32  instruction to datapath
instr_valid  out  1  instr valid; datapath may execute
ex_done  in  1  datapath finished; NextPCSrc/br_target valid this cycle
NextPCSrc  in  1  1 = take br_target (branch taken, jal, jalr)
br_target  in  32  branch/jump target from datapath
halt  in  1  stop fetching after current instruction
pc  out  32  current PC
instret  out  32  retired instruction count
misalign_trap  out  1  sticky misaligned-target flag
halted  out  1  1 while in HALT state

Behaviour:
- Reset: clk edge with rst_n=0 sets state=IDLE, pc=RESET_PC, instr=NOP_INSTR, instret=0, misalign_trap=0. All outputs are registered or decoded from state: imem_req=0, instr_valid=0, halted=0. Any outstanding memory transaction is abandoned.
- States: IDLE, FETCH, WAIT, EXEC, HALT, TRAP.
- IDLE: go to FETCH if halt=0. If halt=1, go to HALT.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_gnt. On imem_gnt=1, go to WAIT; imem_req drops the next cycle. imem_rvalid is ignored in FETCH.
- WAIT: imem_req=0. On imem_rvalid=1, latch instr=imem_rdata and go to EXEC. The wait is unbounded.
- EXEC: instr_valid=1 for the whole state. Wait for ex_done=1, then:
  - Compute cand = NextPCSrc ? {br_target[31:1],1'b0} : pc+4. Bit 0 is always cleared (jalr rule). pc+4 wraps modulo 2^32.
  - If NextPCSrc=1 and br_target[1]=1: go to TRAP. pc keeps the faulting instruction's address and instret is not incremented.
  - Otherwise: pc=cand, instret=instret+1 (wraps), instr=NOP_INSTR. Then go to HALT if halt=1, else FETCH.
- HALT: halted=1, no requests. Go to FETCH on the first cycle with halt=0.
- TRAP: misalign_trap=1, no requests, instr_valid=0. Exit only via reset.
- ex_done, imem_gnt and imem_rvalid outside their consuming state are ignored. The datapath never asserts ex_done with instr_valid=0.
- Minimum cost per instruction, with gnt same-cycle and rvalid one cycle after gnt: FETCH 1 + WAIT 1 + EXEC ≥1 = 3 cycles.
- Reset mid-operation, in any state, returns to IDLE next edge. A late imem_rvalid from the abandoned request arrives while in IDLE/FETCH and is discarded.
- halt asserted during FETCH/WAIT/EXEC does not abort the current instruction. It is sampled only at ex_done, in IDLE, and in HALT.

Test Plan:
- Reset with RESET_PC=0x100; release; gnt immediate; rvalid +1 cycle with 0x00000013; ex_done after 1 cycle with NextPCSrc=0 -> imem_addr=0x100 on the first FETCH cycle, pc=0x104, instret=1, second request at 0x104.
- Hold gnt low 3 cycles, then rvalid 2 cycles after gnt -> imem_req high 4 cycles with imem_addr=pc stable, instr_valid only after rvalid, no extra instret.
- Taken branch: pc=0x200, ex_done with NextPCSrc=1 and br_target=0x1F0 -> pc=0x1F0. jalr with br_target=0x305 -> pc=0x304, no trap.
- Misaligned target: br_target=0x302 with NextPCSrc=1 -> misalign_trap=1, pc unchanged, instret unchanged, imem_req stays 0 for 10 cycles; rst_n low clears it.
- halt=1 asserted mid-WAIT -> the instruction completes, instret increments, halted=1, no requests; halt=0 -> FETCH at the updated pc.
- Reset during WAIT, then a stale rvalid 2 cycles after release -> instr stays NOP_INSTR, pc=RESET_PC, and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/PC controller: owns the PC, fetches over a req/gnt/rvalid
// handshake, hands the instruction to execute and selects the next PC.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        ex_done,
    input  logic        NextPCSrc,
    input  logic [31:0] br_target,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        misalign_trap,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_TRAP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instret_q, instret_d;
    logic        trap_q, trap_d;
    logic [31:0] cand;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            instret_q <= 32'd0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        trap_d    = trap_q;
        // Bit 0 of any taken target is discarded, matching the jalr rule.
        cand      = NextPCSrc ? (br_target & ~32'h1) : (pc_q + 32'd4);
        case (state_q)
            S_IDLE: begin
                state_d = halt ? S_HALT : S_FETCH;
            end
            S_FETCH: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ex_done) begin
                    if (NextPCSrc && br_target[1]) begin
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end else begin
                        pc_d      = cand;
                        instret_d = instret_q + 32'd1;
                        instr_d   = NOP_INSTR;
                        state_d   = halt ? S_HALT : S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req      = (state_q == S_FETCH);
    assign imem_addr     = pc_q;
    assign instr         = instr_q;
    assign instr_valid   = (state_q == S_EXEC);
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign misalign_trap = trap_q;
    assign halted        = (state_q == S_HALT);

endmodule
